// File: rtl/multdiv_sequencer_if.sv
// Start/operand/result bundle between the execute-stage control and the
// multiply/divide sequencer.
interface multdiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply/divide sequencer: works on operand magnitudes
// (shift-add multiply, restoring divide), then restores the sign.
//
// state | meaning
// IDLE  | waiting for a start pulse, busy low
// MUL   | one shift-add step per cycle
// DIV   | one restoring-divide step per cycle
// FIX   | sign restore and overflow detection
// DONE  | ready pulse cycle, result registers updated
module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input logic                 clock,
    input logic                 reset,
    multdiv_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_reg;     // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] acc_hi;     // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo;     // multiplier bits / quotient bits
    logic             sign;
    logic             is_div;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic               mul_ovf;
    logic               div_ovf;

    // -2^31 maps to 2^31, which still fits in the unsigned magnitude register
    assign abs_a = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + WIDTH'(1)) : bus.data_operandA;
    assign abs_b = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + WIDTH'(1)) : bus.data_operandB;

    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_reg} : '0);
    assign mul_next = {mul_sum, acc_lo[WIDTH-1:1]};

    // remainder stays below the divisor, so the low WIDTH bits of the difference are exact
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, op_reg};
    assign div_sub   = div_shift[WIDTH-1:0] - op_reg;

    assign prod_mag    = {acc_hi, acc_lo};
    assign prod_signed = sign ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;
    assign quo_signed  = sign ? (~acc_lo + WIDTH'(1)) : acc_lo;
    assign mul_ovf     = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));
    // only a positive quotient of 2^31 (i.e. -2^31 / -1) is unrepresentable
    assign div_ovf     = !sign && acc_lo[WIDTH-1];

    // Sequencer FSM with registered outputs; a start in any state restarts
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            op_reg             <= '0;
            acc_hi             <= '0;
            acc_lo             <= '0;
            sign               <= 1'b0;
            is_div             <= 1'b0;
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            bus.data_resultRDY <= 1'b0;
            if (bus.ctrl_MULT || bus.ctrl_DIV) begin
                sign     <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                cnt      <= '0;
                acc_hi   <= '0;
                bus.busy <= 1'b1;
                if (bus.ctrl_MULT) begin
                    is_div             <= 1'b0;
                    op_reg             <= abs_a;
                    acc_lo             <= abs_b;
                    bus.data_exception <= 1'b0;
                    state              <= MUL;
                end else if (bus.data_operandB == '0) begin
                    is_div             <= 1'b1;
                    op_reg             <= '0;
                    acc_lo             <= '0;
                    bus.data_result    <= '0;
                    bus.data_exception <= 1'b1;
                    bus.data_resultRDY <= 1'b1;
                    state              <= DONE;
                end else begin
                    is_div             <= 1'b1;
                    op_reg             <= abs_b;
                    acc_lo             <= abs_a;
                    bus.data_exception <= 1'b0;
                    state              <= DIV;
                end
            end else begin
                case (state)
                    IDLE: begin
                        bus.busy <= 1'b0;
                    end
                    MUL: begin
                        {acc_hi, acc_lo} <= mul_next;
                        cnt              <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) state <= FIX;
                    end
                    DIV: begin
                        acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        cnt    <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) state <= FIX;
                    end
                    FIX: begin
                        bus.data_result    <= is_div ? quo_signed : prod_signed[WIDTH-1:0];
                        bus.data_exception <= is_div ? div_ovf : mul_ovf;
                        bus.data_resultRDY <= 1'b1;
                        state              <= DONE;
                    end
                    DONE: begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Multi-cycle signed multiply/divide unit for the execute stage of the 5-stage pipeline.
- Accepts a one-cycle start command from the decode/execute control, then iterates a 32-step shift-add multiplier or restoring divider on operand magnitudes.
- Restores the result sign using two's-complement negation (bitwise invert + 1).
- Raises a one-cycle ready pulse; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ctrl_MULT  in  1  one-cycle pulse: start signed multiply
- ctrl_DIV  in  1  one-cycle pulse: start signed divide
- data_operandA  in  WIDTH  multiplicand / dividend; sampled only in the start cycle
- data_operandB  in  WIDTH  multiplier / divisor; sampled only in the start cycle
- data_result  out  WIDTH  low WIDTH bits of product, or quotient
- data_exception  out  1  overflow or divide-by-zero; valid while data_resultRDY=1
- data_resultRDY  out  1  one-cycle pulse; result and exception valid
- busy  out  1  high while an operation is in flight

Behaviour:
- Reset: synchronous, active-high, clock is the only clock.
  - On reset: state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0; iteration counter=0.
  - Reset mid-operation aborts the operation; no ready pulse is produced.
- States: IDLE, MUL, DIV, FIX, DONE.
- Start (any state except reset):
  - ctrl_MULT=1 in cycle T latches |A|, |B|, sign=A[31]^B[31], clears the accumulator and counter, and goes to MUL.
  - ctrl_DIV=1 (with ctrl_MULT=0) does the same and goes to DIV.
  - ctrl_MULT wins if both are high.
  - A start while busy aborts the current operation and restarts with the new operands (pipeline flush semantics).
- MUL: 32 cycles, T+1..T+32.
  - Each cycle: if the multiplier LSB=1, add the multiplicand to the upper half of the 64-bit product; shift right 1; counter+1.
- DIV: 32 cycles.
  - Each cycle: shift {remainder, quotient} left 1; trial-subtract the divisor from the remainder; if non-negative, keep the difference and set quotient LSB=1.
  - Quotient truncates toward zero; the remainder is discarded.
- Counter reaching 31 in MUL/DIV moves to FIX at T+33.
- FIX (T+33):
  - Negate the magnitude result if sign=1.
  - MUL overflow: exception=1 if signed 64-bit bits [63:31] are not all equal.
  - DIV overflow: A=0x80000000 and B=0xFFFFFFFF gives result 0x80000000 and exception=1.
- DONE (T+34):
  - data_resultRDY=1 for exactly one cycle; data_result and data_exception are updated at the same edge.
  - Next state is IDLE.
- data_result and data_exception hold their values until the next completion; data_exception is cleared at the next start.
- Divide by zero: B=0 with ctrl_DIV at T skips iteration and goes straight to DONE. Ready pulses at T+1 with data_result=0 and data_exception=1.
- Zero operands take the normal latency: result 0, exception 0.
- Magnitude of 0x80000000 is 2^31, held in an unsigned 32-bit register; -2^31 operands must compute correctly.
- busy=1 from T+1 through DONE inclusive; busy=0 in IDLE.
- Operand inputs may change freely after T.

Test Plan:
- ctrl_MULT at T with A=7, B=-3 -> data_resultRDY pulses at T+34 only; data_result=0xFFFFFFEB (-21), exception=0; busy high T+1..T+34.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> at T+34: data_result=0x00000000, exception=1. Then A=0x80000000, B=1 -> result 0x80000000, exception=0.
- ctrl_DIV with A=-100, B=7 -> at T+34: result 0xFFFFFFF2 (-14), exception=0. Then A=0x80000000, B=-1 -> result 0x80000000, exception=1.
- ctrl_DIV with A=5, B=0 -> ready at T+1: result 0, exception=1, busy low again by T+2.
- ctrl_MULT 6*7 at T, then ctrl_DIV 100/10 at T+10 -> no pulse at T+34; single pulse at T+44 with result 10.
- ctrl_MULT at T, reset asserted at T+5 for one cycle -> all outputs 0 from T+6 on; no ready pulse; the next ctrl_MULT 3*3 completes normally with result 9.
